// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen -- multi-channel fractional clock-enable generator
//
// Each channel is a phase accumulator. On every accumulator carry it emits a
// one-cycle tick strobe and toggles a square wave, so the tick rate is
// f_clk*inc/2^ACC_W and the square wave runs at half of that. Increments are
// retuned glitch-free through a per-channel shadow register. The shadow is
// only copied into the active increment on a tick edge or when the channel
// starts. A run/stop handshake stops a channel only when its square wave is
// low.
//
// Optional feature macro: CLK_EN_GEN_STATS_EN
//   defined   : tick_cnt_o carries a 32-bit tick counter per channel
//   undefined : tick_cnt_o is tied to zero and no counter logic exists
//
// Ports
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   cfg_we_i    write cfg_inc_i into the shadow increment of channel cfg_ch_i
//   cfg_ch_i    channel select for cfg_we_i (values >= NUM_CH are ignored)
//   cfg_inc_i   new increment value
//   run_req_i   per-channel level request to run
//   running_o   1 while the channel is in RUN or DRAIN
//   tick_o      one-cycle strobe on accumulator carry
//   sq_o        square wave, toggles on every tick
//   tick_cnt_o  per-channel tick counters, channel 0 in [31:0]
// -----------------------------------------------------------------------------
module clk_en_gen #(
   parameter int                NUM_CH      = 4,
   parameter int                ACC_W       = 24,
   parameter logic [ACC_W-1:0]  DEFAULT_INC = 24'h15798F,
   parameter int                CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_we_i,
   input  logic [CH_W-1:0]      cfg_ch_i,
   input  logic [ACC_W-1:0]     cfg_inc_i,
   input  logic [NUM_CH-1:0]    run_req_i,
   output logic [NUM_CH-1:0]    running_o,
   output logic [NUM_CH-1:0]    tick_o,
   output logic [NUM_CH-1:0]    sq_o,
   output logic [NUM_CH*32-1:0] tick_cnt_o
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_e           state_q, state_d;
      logic [ACC_W-1:0] acc_q, acc_d;
      logic [ACC_W-1:0] act_q, act_d;
      logic [ACC_W-1:0] shd_q, shd_d;
      logic             run_q, run_d;
      logic             tick_q, tick_d;
      logic             sq_q, sq_d;
      logic [ACC_W:0]   sum;
      logic             carry;
      logic             wr_hit;

      // One extra bit so the carry out of the wrapping add is never lost.
      assign sum    = {1'b0, acc_q} + {1'b0, act_q};
      assign carry  = sum[ACC_W];
      // Out-of-range channel numbers match no g and are dropped here.
      assign wr_hit = cfg_we_i && (cfg_ch_i == CH_W'(g));

      always_comb begin
         state_d = state_q;
         acc_d   = acc_q;
         act_d   = act_q;
         run_d   = run_q;
         tick_d  = 1'b0;
         sq_d    = sq_q;
         shd_d   = wr_hit ? cfg_inc_i : shd_q;

         case (state_q)
            ST_STOP: begin
               acc_d = '0;
               run_d = 1'b0;
               sq_d  = 1'b0;
               if (run_req_i[g]) begin
                  state_d = ST_START;
               end
            end
            ST_START: begin
               acc_d   = '0;
               act_d   = shd_q;
               run_d   = 1'b1;
               state_d = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
               acc_d  = sum[ACC_W-1:0];
               tick_d = carry;
               run_d  = 1'b1;
               // shd_q (not shd_d) so a write landing on a tick edge only
               // takes effect at the following tick.
               if (carry) begin
                  sq_d  = ~sq_q;
                  act_d = shd_q;
               end
               if (run_req_i[g]) begin
                  state_d = ST_RUN;
               end else if (state_q == ST_RUN) begin
                  state_d = ST_DRAIN;
               end else if (act_q == '0) begin
                  // A zero rate would never produce the falling tick.
                  state_d = ST_STOP;
                  sq_d    = 1'b0;
               end else if (carry && sq_q) begin
                  state_d = ST_STOP;
               end
            end
            default: begin
               state_d = ST_STOP;
            end
         endcase
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q <= ST_STOP;
            acc_q   <= '0;
            act_q   <= DEFAULT_INC;
            shd_q   <= DEFAULT_INC;
            run_q   <= 1'b0;
            tick_q  <= 1'b0;
            sq_q    <= 1'b0;
         end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            run_q   <= run_d;
            tick_q  <= tick_d;
            sq_q    <= sq_d;
         end
      end

      assign running_o[g] = run_q;
      assign tick_o[g]    = tick_q;
      assign sq_o[g]      = sq_q;

`ifdef CLK_EN_GEN_STATS_EN
      logic [31:0] cnt_q, cnt_d;

      // tick_d is only ever set in RUN/DRAIN, so the count holds in STOP.
      always_comb begin
         cnt_d = cnt_q;
         if (state_q == ST_START) begin
            cnt_d = '0;
         end else if (tick_d) begin
            cnt_d = cnt_q + 32'd1;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign tick_cnt_o[g*32 +: 32] = cnt_q;
`else
      assign tick_cnt_o[g*32 +: 32] = '0;
`endif
   end : g_ch

endmodule : clk_en_gen

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;

   localparam int          NUM_CH  = 4;
   localparam int          ACC_W   = 24;
   localparam int          CH_W    = 2;
   localparam logic [23:0] DEF_INC = 24'h15798F;
   localparam longint      MODV    = 64'd1 << ACC_W;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 cfg_we = 1'b0;
   logic [CH_W-1:0]      cfg_ch = '0;
   logic [ACC_W-1:0]     cfg_inc = '0;
   logic [NUM_CH-1:0]    run_req = '0;
   logic [NUM_CH-1:0]    running;
   logic [NUM_CH-1:0]    tick;
   logic [NUM_CH-1:0]    sq;
   logic [NUM_CH*32-1:0] tick_cnt;

   always #5 clk = ~clk;

   clk_en_gen #(
      .NUM_CH     (NUM_CH),
      .ACC_W      (ACC_W),
      .DEFAULT_INC(DEF_INC)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .cfg_we_i   (cfg_we),
      .cfg_ch_i   (cfg_ch),
      .cfg_inc_i  (cfg_inc),
      .run_req_i  (run_req),
      .running_o  (running),
      .tick_o     (tick),
      .sq_o       (sq),
      .tick_cnt_o (tick_cnt)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural reference: 0 stop, 1 start, 2 run, 3 drain
   int          m_st  [NUM_CH];
   longint      m_acc [NUM_CH];
   logic [23:0] m_act [NUM_CH];
   logic [23:0] m_sh  [NUM_CH];
   logic [31:0] m_cnt [NUM_CH];
   logic [NUM_CH-1:0] m_run, m_tick, m_sq;

   typedef struct packed {
      logic [NUM_CH-1:0]    run;
      logic [NUM_CH-1:0]    tck;
      logic [NUM_CH-1:0]    sqw;
      logic [NUM_CH*32-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   task automatic model_step();
      exp_t e;
      for (int c = 0; c < NUM_CH; c++) begin
         int          st;
         longint      nxt;
         bit          cy;
         logic [23:0] act_old;
         logic [23:0] sh_old;
         bit          sq_old;
         st      = m_st[c];
         act_old = m_act[c];
         sh_old  = m_sh[c];
         sq_old  = m_sq[c];
         if (rst) begin
            m_st[c] = 0; m_acc[c] = 0; m_act[c] = DEF_INC; m_sh[c] = DEF_INC;
            m_cnt[c] = 0; m_run[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
            continue;
         end
         if (cfg_we && int'(cfg_ch) == c) m_sh[c] = cfg_inc;
         m_tick[c] = 0;
         if (st == 0) begin
            m_acc[c] = 0; m_run[c] = 0; m_sq[c] = 0;
            if (run_req[c]) m_st[c] = 1;
         end else if (st == 1) begin
            m_acc[c] = 0; m_act[c] = sh_old; m_run[c] = 1; m_cnt[c] = 0; m_st[c] = 2;
         end else begin
            nxt = m_acc[c] + longint'(act_old);
            cy  = (nxt >= MODV);
            m_acc[c]  = cy ? nxt - MODV : nxt;
            m_tick[c] = cy;
            m_run[c]  = 1;
            if (cy) begin
               m_sq[c]  = ~sq_old;
               m_act[c] = sh_old;
               m_cnt[c] = m_cnt[c] + 1;
            end
            if (run_req[c])             m_st[c] = 2;
            else if (st == 2)           m_st[c] = 3;
            else if (act_old == 24'h0) begin m_st[c] = 0; m_sq[c] = 0; end
            else if (cy && sq_old)      m_st[c] = 0;
         end
      end
      e.run = m_run;
      e.tck = m_tick;
      e.sqw = m_sq;
      e.cnt = '0;
`ifdef CLK_EN_GEN_STATS_EN
      for (int c = 0; c < NUM_CH; c++) e.cnt[c*32 +: 32] = m_cnt[c];
`endif
      exp_q.push_back(e);
   endtask

   // One clock: predict, clock, compare the DUT against the oldest prediction.
   task automatic step();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_val("outs{run,tick,sq}", {running, tick, sq}, {e.run, e.tck, e.sqw});
      check_val("tick_cnt", tick_cnt, e.cnt);
   endtask

   task automatic wait_tick(input int ch, input int max, output int n);
      n = 0;
      repeat (max) begin
         step();
         n++;
         if (tick[ch]) return;
      end
      n = -1;
   endtask

   task automatic wait_run(input int ch, input logic val, input int max, output int n);
      n = 0;
      repeat (max) begin
         step();
         n++;
         if (running[ch] == val) return;
      end
      n = -1;
   endtask

   task automatic write_inc(input int ch, input logic [23:0] v);
      cfg_we  = 1'b1;
      cfg_ch  = CH_W'(ch);
      cfg_inc = v;
      step();
      cfg_we  = 1'b0;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cnt [NUM_CH];
      int first0;

      // Reset
      rst = 1'b1;
      step();
      step();
      check_val("rst_outs", {running, tick, sq}, 12'h0);
      check_val("rst_cnt", tick_cnt, 128'h0);
      rst = 1'b0;

      // ch0 at half rate: ticks every 2 clk, square period 4 clk
      write_inc(0, 24'h800000);
      run_req[0] = 1'b1;
      wait_run(0, 1'b1, 10, n);  check_val("t1_run_lat", n, 2);
      wait_tick(0, 10, n);       check_val("t1_first_tick", n, 2);
      check_val("t1_sq_hi", sq[0], 1'b1);
      wait_tick(0, 10, n);       check_val("t1_gap2", n, 2);
      check_val("t1_sq_lo", sq[0], 1'b0);
      wait_tick(0, 10, n);       check_val("t1_gap3", n, 2);
      run_req[0] = 1'b0;
      wait_run(0, 1'b0, 20, n);  check_val("t1_stop", n, 3);

      // ch1 retune mid-period: old spacing holds until the next tick
      write_inc(1, 24'h400000);
      run_req[1] = 1'b1;
      wait_run(1, 1'b1, 10, n);  check_val("t2_run_lat", n, 2);
      wait_tick(1, 10, n);       check_val("t2_first_tick", n, 4);
      write_inc(1, 24'h800000);
      wait_tick(1, 10, n);       check_val("t2_old_gap_rest", n, 3);
      wait_tick(1, 10, n);       check_val("t2_new_gap", n, 2);
      step();
      // write lands on the tick edge: pre-write shadow is the one copied
      write_inc(1, 24'h400000);
      check_val("t2_tick_on_write", tick[1], 1'b1);
      wait_tick(1, 10, n);       check_val("t2_same_edge_gap", n, 2);
      wait_tick(1, 10, n);       check_val("t2_applied_gap", n, 4);

      // ch2: drop request while sq high -> one more tick, then stop
      write_inc(2, 24'h400000);
      run_req[2] = 1'b1;
      wait_tick(2, 20, n);       check_val("t3_first_tick", n, 6);
      check_val("t3_sq_hi", sq[2], 1'b1);
      run_req[2] = 1'b0;
      wait_tick(2, 10, n);       check_val("t3_drain_tick", n, 4);
      check_val("t3_sq_fell", sq[2], 1'b0);
      check_val("t3_run_still", running[2], 1'b1);
      step();
      check_val("t3_run_fell", running[2], 1'b0);
      n = 0;
      repeat (20) begin
         step();
         if (tick[2]) n++;
      end
      check_val("t3_no_ticks", n, 0);

      // ch3: drain with zero increment taking effect on the rising tick
      write_inc(3, 24'h400000);
      run_req[3] = 1'b1;
      wait_tick(3, 20, n);       check_val("t4_tick1", n, 6);
      wait_tick(3, 10, n);       check_val("t4_tick2", n, 4);
      check_val("t4_sq_lo", sq[3], 1'b0);
      run_req[3] = 1'b0;
      write_inc(3, 24'h000000);
      wait_tick(3, 10, n);       check_val("t4_drain_tick", n, 3);
      check_val("t4_sq_rose", sq[3], 1'b1);
      step();
      check_val("t4_sq_forced", sq[3], 1'b0);
      check_val("t4_no_tick", tick[3], 1'b0);
      step();
      check_val("t4_run_fell", running[3], 1'b0);

      // Reset mid-run on all channels (ch3 runs with inc 0: no ticks, running high)
      run_req = 4'hF;
      repeat (10) step();
      check_val("t6_all_running", running, 4'hF);
      write_inc(0, 24'h800000);
      rst = 1'b1;
      step();
      check_val("t6_rst_outs", {running, tick, sq}, 12'h0);
      check_val("t6_rst_cnt", tick_cnt, 128'h0);
      step();
      rst = 1'b0;

      // Default increment on all channels for 1000 clk
      wait_run(0, 1'b1, 10, n);  check_val("t5_run_lat", n, 2);
      check_val("t5_all_running", running, 4'hF);
      for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
      first0 = -1;
      for (int k = 1; k <= 1000; k++) begin
         step();
         for (int c = 0; c < NUM_CH; c++) if (tick[c]) cnt[c]++;
         if (tick[0] && first0 < 0) first0 = k;
      end
      check_val("t6_default_first_tick", first0, 12);
      for (int c = 0; c < NUM_CH; c++) begin
         check_val($sformatf("t5_ticks_in_range_ch%0d", c), (cnt[c] >= 83 && cnt[c] <= 84), 1'b1);
`ifdef CLK_EN_GEN_STATS_EN
         check_val($sformatf("t5_cnt_ch%0d", c), tick_cnt[c*32 +: 32], cnt[c]);
`else
         check_val($sformatf("t5_cnt_zero_ch%0d", c), tick_cnt[c*32 +: 32], 32'h0);
`endif
      end
      run_req = 4'h0;
      n = 0;
      repeat (40) begin
         step();
         n++;
         if (running == 4'h0) break;
      end
      check_val("t5_all_stopped", running, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_clk_en_gen
